// File: rtl/row_reconstructor.sv
// -----------------------------------------------------------------------------
// row_reconstructor
//
// Inverse integer CDF 5/3 lifting for one row of LENGTH samples, with symmetric
// extension at both ends. Coefficient pairs (s[n], d[n]) arrive one per
// accepted cycle. Each accepted pair yields the even sample x[2n] and, once a
// previous pair is known, the odd sample x[2n-1]. The last odd sample
// x[LENGTH-1] is written in a single flush cycle, and that cycle also raises
// result.
//
// Parameters
//   LENGTH   samples per row (even, >= 4)
//
// Ports
//   clk       system clock, rising edge
//   resetn    asynchronous active-low reset
//   en        start pulse, accepted only while idle
//   in_valid  qualifies s/d as one coefficient pair while loading
//   s         lowpass coefficient, unsigned 8 bit
//   d         highpass coefficient, two's complement 8 bit
//   out       reconstructed row, out[8*i +: 8] = x[i]
//   busy      high from the accepted en until result
//   result    one-cycle pulse when out holds a complete row
// -----------------------------------------------------------------------------
module row_reconstructor #(
    parameter int LENGTH = 8
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  en,
    input  logic                  in_valid,
    input  logic [7:0]            s,
    input  logic [7:0]            d,
    output logic [8*LENGTH-1:0]   out,
    output logic                  busy,
    output logic                  result
);

    localparam int N      = LENGTH / 2;
    localparam int CNT_W  = (N > 1) ? $clog2(N) : 1;
    localparam int DATA_W = 8;
    localparam int IW     = 11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FLUSH
    } state_t;

    state_t                  state, state_nxt;
    logic [CNT_W-1:0]        cnt;
    logic [DATA_W-1:0]       d_prev;
    logic [DATA_W-1:0]       x_prev;

    logic                    start;
    logic                    accept;
    logic                    flush;

    logic [DATA_W-1:0]       dp;
    logic signed [IW-1:0]    even_sum;
    logic signed [IW-1:0]    xe_wide;
    logic signed [IW-1:0]    xo_wide;
    logic signed [IW-1:0]    xl_wide;
    logic [DATA_W-1:0]       xe;
    logic [DATA_W-1:0]       xo;
    logic [DATA_W-1:0]       xl;

    // Rounding and truncation helpers
    function automatic logic signed [IW-1:0] zext(input logic [DATA_W-1:0] v);
        return $signed({{(IW-DATA_W){1'b0}}, v});
    endfunction

    function automatic logic signed [IW-1:0] sext(input logic [DATA_W-1:0] v);
        return $signed({{(IW-DATA_W){v[DATA_W-1]}}, v});
    endfunction

    function automatic logic signed [IW-1:0] floor_div4(input logic signed [IW-1:0] v);
        return v >>> 2;
    endfunction

    function automatic logic signed [IW-1:0] floor_div2(input logic signed [IW-1:0] v);
        return v >>> 1;
    endfunction

    function automatic logic [DATA_W-1:0] wrap8(input logic signed [IW-1:0] v);
        return v[DATA_W-1:0];
    endfunction

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and cycle qualifiers
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        accept    = 1'b0;
        flush     = 1'b0;
        case (state)
            ST_IDLE: begin
                // A pair presented together with en is not consumed.
                if (en) begin
                    start     = 1'b1;
                    state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (in_valid) begin
                    accept = 1'b1;
                    if (cnt == CNT_W'(N - 1)) begin
                        state_nxt = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                flush     = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Lifting datapath. Odd samples use the already-wrapped even samples so
    // that the mod-256 round trip with the forward transform is exact.
    always_comb begin
        dp       = (cnt == '0) ? d : d_prev;   // d[-1] mirrors d[0]
        even_sum = sext(dp) + sext(d) + IW'(2);
        xe_wide  = zext(s) - floor_div4(even_sum);
        xe       = wrap8(xe_wide);
        xo_wide  = sext(d_prev) + floor_div2(zext(x_prev) + zext(xe));
        xo       = wrap8(xo_wide);
        // x[LENGTH] mirrors x[LENGTH-2], so the average collapses to x[LENGTH-2].
        xl_wide  = sext(d_prev) + zext(x_prev);
        xl       = wrap8(xl_wide);
    end

    // Control registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt    <= '0;
            busy   <= 1'b0;
            result <= 1'b0;
        end else begin
            result <= flush;
            if (start) begin
                cnt  <= '0;
                busy <= 1'b1;
            end else if (accept) begin
                cnt  <= cnt + CNT_W'(1);
            end
            if (flush) begin
                busy <= 1'b0;
            end
        end
    end

    // Row storage and lifting history
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out    <= '0;
            d_prev <= '0;
            x_prev <= '0;
        end else begin
            if (accept) begin
                d_prev <= d;
                x_prev <= xe;
                for (int i = 0; i < N; i++) begin
                    if (cnt == CNT_W'(i)) begin
                        out[16*i +: 8] <= xe;
                    end
                end
                for (int i = 1; i < N; i++) begin
                    if (cnt == CNT_W'(i)) begin
                        out[16*i-8 +: 8] <= xo;
                    end
                end
            end
            if (flush) begin
                out[8*(LENGTH-1) +: 8] <= xl;
            end
        end
    end

endmodule

// File: tb/tb_row_reconstructor.sv
// -----------------------------------------------------------------------------
// tb_row_reconstructor
//
// Scoreboard bench for row_reconstructor (LENGTH = 8). The stimulus process
// pushes the expected row and the cycle on which result must appear; a monitor
// on the falling edge pops and compares whenever result is high.
// -----------------------------------------------------------------------------
module tb_row_reconstructor;

    localparam int LENGTH = 8;
    localparam int N      = LENGTH / 2;

    logic                clk;
    logic                resetn;
    logic                en;
    logic                in_valid;
    logic [7:0]          s;
    logic [7:0]          d;
    logic [8*LENGTH-1:0] out_w;
    logic                busy;
    logic                result;

    typedef struct {
        logic [8*LENGTH-1:0] row;
        int                  cyc;
    } exp_t;

    exp_t q[$];
    int   n_tests;
    int   n_fail;
    int   cyc;
    logic prev_result;

    row_reconstructor #(.LENGTH(LENGTH)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .en       (en),
        .in_valid (in_valid),
        .s        (s),
        .d        (d),
        .out      (out_w),
        .busy     (busy),
        .result   (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compare whenever the DUT presents a finished row
    initial prev_result = 1'b0;
    always @(negedge clk) begin
        if (resetn) begin
            if (result) begin
                chk("result_one_cycle", {63'd0, prev_result}, 64'd0);
                chk("busy_at_result", {63'd0, busy}, 64'd0);
                if (q.size() == 0) begin
                    chk("unexpected_result", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("row_out", out_w, e.row);
                    chk("result_latency", 64'(cyc), 64'(e.cyc));
                end
            end
            prev_result = result;
        end else begin
            prev_result = 1'b0;
        end
    end

    // Forward CDF 5/3 with mod-256 storage
    task automatic fwd(input logic [7:0] x[LENGTH], output logic [7:0] so[N], output logic [7:0] dout[N]);
        int t, sd, sdp;
        logic [7:0] xe2;
        for (int n = 0; n < N; n++) begin
            xe2 = (n == N - 1) ? x[LENGTH-2] : x[2*n+2];
            t = int'(x[2*n+1]) - ((int'(x[2*n]) + int'(xe2)) >>> 1);
            dout[n] = t[7:0];
        end
        for (int n = 0; n < N; n++) begin
            sd  = int'($signed(dout[n]));
            sdp = (n == 0) ? sd : int'($signed(dout[n-1]));
            t = int'(x[2*n]) + ((sdp + sd + 2) >>> 2);
            so[n] = t[7:0];
        end
    endtask

    task automatic start_row();
        @(negedge clk);
        en       = 1'b1;
        in_valid = 1'b0;
    endtask

    task automatic send_row(input logic [7:0] sa[N], input logic [7:0] da[N],
                            input logic [63:0] exp_row, input int gap);
        exp_t e;
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            en       = 1'b0;
            s        = sa[i];
            d        = da[i];
            in_valid = 1'b1;
            if (i == N - 1) begin
                e.row = exp_row;
                e.cyc = cyc + 2;
                q.push_back(e);
            end
            if (i != N - 1) begin
                for (int g = 0; g < gap; g++) begin
                    @(negedge clk);
                    in_valid = 1'b0;
                end
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while ((q.size() != 0 || busy) && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) chk("row_timeout", 64'd1, 64'd0);
        @(negedge clk);
    endtask

    task automatic run_row(input logic [63:0] row);
        logic [7:0] x[LENGTH];
        logic [7:0] sa[N];
        logic [7:0] da[N];
        for (int i = 0; i < LENGTH; i++) x[i] = row[8*i +: 8];
        fwd(x, sa, da);
        start_row();
        send_row(sa, da, row, 0);
        wait_done();
    endtask

    localparam logic [63:0] RAMP = 64'h0706050403020100;

    initial begin
        logic [7:0] ramp_s[N];
        logic [7:0] ramp_d[N];
        logic [7:0] c_s[N];
        logic [7:0] c_d[N];
        logic [63:0] rows[6];
        logic [63:0] r;

        n_tests  = 0;
        n_fail   = 0;
        resetn   = 1'b0;
        en       = 1'b0;
        in_valid = 1'b0;
        s        = '0;
        d        = '0;
        ramp_s   = '{8'd0, 8'd2, 8'd4, 8'd6};
        ramp_d   = '{8'd0, 8'd0, 8'd0, 8'd1};

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset_out", out_w, 64'd0);
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_result", {63'd0, result}, 64'd0);
        resetn = 1'b1;
        @(negedge clk);

        // Ramp, back-to-back pairs
        start_row();
        @(posedge clk);
        #1 chk("busy_after_en", {63'd0, busy}, 64'd1);
        send_row(ramp_s, ramp_d, RAMP, 0);
        wait_done();
        chk("busy_after_ramp", {63'd0, busy}, 64'd0);

        // Constant 100
        c_s = '{8'd100, 8'd100, 8'd100, 8'd100};
        c_d = '{8'd0, 8'd0, 8'd0, 8'd0};
        start_row();
        send_row(c_s, c_d, {8{8'd100}}, 0);
        wait_done();
        chk("busy_after_const", {63'd0, busy}, 64'd0);
        chk("result_low_after_const", {63'd0, result}, 64'd0);

        // Ramp with 3-cycle valid gaps
        start_row();
        send_row(ramp_s, ramp_d, RAMP, 3);
        wait_done();

        // Wrap and negative-d rows through the forward model
        rows[0] = 64'hFF00FF00FF00FF00;
        rows[1] = 64'h00FF00FF00FF00FF;
        rows[2] = 64'h01C8034DFF800A00;
        rows[3] = 64'h00000000000000FF;
        rows[4] = 64'hFFFFFFFFFFFFFF00;
        rows[5] = 64'h7F80017E00FE02FF;
        for (int k = 0; k < 6; k++) run_row(rows[k]);
        for (int k = 0; k < 4; k++) begin
            r = {$urandom, $urandom};
            r[7:0]   = 8'h00;
            r[47:40] = 8'hFF;
            run_row(r);
        end

        // Reset in the middle of a row
        start_row();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            en = 1'b0;
            s = ramp_s[i];
            d = ramp_d[i];
            in_valid = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        resetn   = 1'b0;
        #1;
        chk("midrow_reset_out", out_w, 64'd0);
        chk("midrow_reset_busy", {63'd0, busy}, 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        repeat (2) @(negedge clk);
        chk("no_start_after_reset", {63'd0, busy}, 64'd0);
        start_row();
        send_row(ramp_s, ramp_d, RAMP, 0);
        wait_done();

        // in_valid while idle leaves everything alone
        @(negedge clk);
        s = 8'd55;
        d = 8'd9;
        in_valid = 1'b1;
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("idle_valid_out", out_w, RAMP);
        chk("idle_valid_busy", {63'd0, busy}, 64'd0);

        // en together with a junk pair, en pulsed mid-row, noise during flush
        c_s = '{8'd50, 8'd50, 8'd50, 8'd50};
        @(negedge clk);
        en = 1'b1;
        in_valid = 1'b1;
        s = 8'd99;
        d = 8'd5;
        for (int i = 0; i < N; i++) begin
            exp_t e;
            @(negedge clk);
            en = 1'b0;
            s = c_s[i];
            d = 8'd0;
            in_valid = 1'b1;
            if (i == N - 1) begin
                e.row = {8{8'd50}};
                e.cyc = cyc + 2;
                q.push_back(e);
            end
            if (i == 1) begin
                @(negedge clk);
                en = 1'b1;
                in_valid = 1'b0;
            end
        end
        @(negedge clk);
        en = 1'b1;
        in_valid = 1'b1;
        s = 8'd3;
        d = 8'd77;
        @(negedge clk);
        en = 1'b0;
        in_valid = 1'b0;
        wait_done();
        chk("protocol_busy_end", {63'd0, busy}, 64'd0);

        chk("queue_drained", 64'(q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
